// File: rtl/bus_timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer.
package bus_timer_pkg;

  // Register offsets, decoded from addr[3:2]
  localparam logic [1:0] CTRL_OFF   = 2'd0;
  localparam logic [1:0] PRESET_OFF = 2'd1;
  localparam logic [1:0] COUNT_OFF  = 2'd2;
  localparam logic [1:0] RSVD_OFF   = 2'd3;

  // CTRL field positions
  localparam int EN_BIT   = 0;
  localparam int MODE_LSB = 1;
  localparam int IM_BIT   = 3;

  // MODE encodings; 1x behaves as one-shot
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    CNT  = 2'b10,
    INT  = 2'b11
  } state_e;

  // Per-byte merge of a bus write into an existing 32-bit register
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/bus_timer_prescaler.sv
// Prescale counter: counts 0..PRESCALE-1 while run_i is high, ticks on the
// last value and wraps. Held at zero whenever the timer is not counting.
module timer_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic run_i,
  output logic tick_o
);

  localparam logic [15:0] LAST = 16'(PRESCALE - 1);

  logic [15:0] cnt_q, cnt_d;

  assign tick_o = run_i && (cnt_q == LAST);

  // Next count: advance while running, wrap on tick, clear otherwise
  always_comb begin
    cnt_d = '0;
    if (run_i && !tick_o) cnt_d = cnt_q + 16'd1;
  end

  // Prescale counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped countdown timer with one-shot / auto-reload modes and a
// maskable interrupt. Read data is combinational, like data memory.
module bus_timer
  import bus_timer_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [3:0]  addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  state_e      state_q, state_d;
  logic        en_q, en_d;
  logic [1:0]  mode_q, mode_d;
  logic        im_q, im_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        pend_q, pend_d;

  logic        tick;
  logic        wr, wr_ctrl, wr_pre, expire;
  logic        unused_addr;

  assign unused_addr = ^addr[1:0];

  timer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .run_i  (state_q == CNT),
    .tick_o (tick)
  );

  assign wr      = sel && (byteen != 4'b0000);
  assign wr_ctrl = wr && (addr[3:2] == CTRL_OFF) && byteen[0];
  assign wr_pre  = wr && (addr[3:2] == PRESET_OFF);
  assign expire  = (state_q == CNT) && en_q && tick && (count_q <= 32'd1);

  // FSM next state and register updates; CPU CTRL writes override the FSM
  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    mode_d   = mode_q;
    im_d     = im_q;
    preset_d = preset_q;
    count_d  = count_q;
    pend_d   = pend_q;

    case (state_q)
      IDLE: if (en_q) state_d = LOAD;
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!en_q) begin
          state_d = IDLE;
        end else if (tick) begin
          if (count_q > 32'd1) begin
            count_d = count_q - 32'd1;
          end else begin
            count_d = '0;
            pend_d  = 1'b1;
            state_d = INT;
          end
        end
      end
      INT: begin
        if (mode_q == MODE_RELOAD) begin
          pend_d  = 1'b0;
          state_d = LOAD;
        end else begin
          en_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A fresh expiry in the same cycle outranks the write's pending clear
    if (wr_ctrl) begin
      en_d   = wdata[EN_BIT];
      mode_d = wdata[MODE_LSB +: 2];
      im_d   = wdata[IM_BIT];
      if (!expire) pend_d = 1'b0;
    end

    if (wr_pre) preset_d = merge_bytes(preset_q, wdata, byteen);
  end

  // State and register file
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      en_q     <= 1'b0;
      mode_q   <= MODE_ONESHOT;
      im_q     <= 1'b0;
      preset_q <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
    end
  end

  // Combinational read mux, independent of sel/byteen
  always_comb begin
    rdata = '0;
    case (addr[3:2])
      CTRL_OFF:   rdata = {28'b0, im_q, mode_q, en_q};
      PRESET_OFF: rdata = preset_q;
      COUNT_OFF:  rdata = count_q;
      default:    rdata = '0;
    endcase
  end

  assign irq = pend_q & im_q;

endmodule

// File: tb/tb_bus_timer.sv
module tb_bus_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sel = 1'b0;
  logic [3:0]  addr = '0;
  logic [3:0]  byteen = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata_p1, rdata_p4;
  logic        irq_p1, irq_p4;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  bus_timer #(.PRESCALE(1)) u_p1 (
    .clk(clk), .reset(reset), .sel(sel), .addr(addr), .byteen(byteen),
    .wdata(wdata), .rdata(rdata_p1), .irq(irq_p1)
  );

  bus_timer #(.PRESCALE(4)) u_p4 (
    .clk(clk), .reset(reset), .sel(sel), .addr(addr), .byteen(byteen),
    .wdata(wdata), .rdata(rdata_p4), .irq(irq_p4)
  );

  // Reference model: the count is derived from cycles elapsed since the
  // reload (count = N - elapsed/P, expiry at elapsed == N*P).
  localparam int PH_OFF = 0, PH_ARM = 1, PH_RUN = 2, PH_FIRE = 3;

  typedef struct {
    bit        en;
    bit [1:0]  mode;
    bit        im;
    bit [31:0] preset;
    bit [31:0] count;
    bit        pend;
    int        phase;
    longint    n_eff;
    longint    elapsed;
  } mdl_t;

  mdl_t m1, m4;

  function automatic mdl_t mdl_zero();
    mdl_t z;
    z = '{default: 0};
    return z;
  endfunction

  function automatic mdl_t mdl_next(mdl_t m, int p, bit s, bit [3:0] a,
                                    bit [3:0] be, bit [31:0] wd);
    mdl_t n;
    bit   fired;
    n = m;
    fired = 1'b0;
    case (m.phase)
      PH_OFF: if (m.en) n.phase = PH_ARM;
      PH_ARM: begin
        n.count   = m.preset;
        n.n_eff   = (m.preset == 0) ? 1 : longint'(m.preset);
        n.elapsed = 0;
        n.phase   = PH_RUN;
      end
      PH_RUN: begin
        if (!m.en) begin
          n.phase = PH_OFF;
        end else begin
          n.elapsed = m.elapsed + 1;
          if (n.elapsed >= m.n_eff * p) begin
            n.count = 0;
            n.pend  = 1'b1;
            fired   = 1'b1;
            n.phase = PH_FIRE;
          end else if (m.count != 0) begin
            n.count = 32'(m.n_eff - n.elapsed / p);
          end
        end
      end
      default: begin
        if (m.mode == 2'b01) begin
          n.pend  = 1'b0;
          n.phase = PH_ARM;
        end else begin
          n.en    = 1'b0;
          n.phase = PH_OFF;
        end
      end
    endcase
    if (s && be != 4'b0) begin
      if (a[3:2] == 2'd0 && be[0]) begin
        n.en   = wd[0];
        n.mode = wd[2:1];
        n.im   = wd[3];
        if (!fired) n.pend = 1'b0;
      end
      if (a[3:2] == 2'd1)
        for (int b = 0; b < 4; b++)
          if (be[b]) n.preset[8*b +: 8] = wd[8*b +: 8];
    end
    return n;
  endfunction

  function automatic logic [31:0] mdl_read(mdl_t m, logic [3:0] a);
    case (a[3:2])
      2'd0:    return {28'b0, m.im, m.mode, m.en};
      2'd1:    return m.preset;
      2'd2:    return m.count;
      default: return 32'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Drive bus inputs after the falling edge and compare both DUTs with the model
  task automatic drive(input bit s, input bit [3:0] a, input bit [3:0] be, input bit [31:0] wd);
    @(negedge clk);
    sel = s; addr = a; byteen = be; wdata = wd;
    #1;
    chk("p1_rdata", rdata_p1, mdl_read(m1, a));
    chk("p1_irq", {31'b0, irq_p1}, {31'b0, m1.pend & m1.im});
    chk("p4_rdata", rdata_p4, mdl_read(m4, a));
    chk("p4_irq", {31'b0, irq_p4}, {31'b0, m4.pend & m4.im});
  endtask

  task automatic edge_update();
    @(posedge clk);
    m1 = mdl_next(m1, 1, sel, addr, byteen, wdata);
    m4 = mdl_next(m4, 4, sel, addr, byteen, wdata);
  endtask

  task automatic step(input bit s, input bit [3:0] a, input bit [3:0] be, input bit [31:0] wd);
    drive(s, a, be, wd);
    edge_update();
  endtask

  task automatic wr(input bit [3:0] a, input bit [31:0] d);
    step(1'b1, a, 4'hF, d);
  endtask

  task automatic rd(input bit [3:0] a, input int n);
    for (int i = 0; i < n; i++) step(1'b0, a, 4'h0, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; sel = 1'b0; addr = 4'h8; byteen = '0; wdata = '0;
    m1 = mdl_zero();
    m4 = mdl_zero();
    #1;
    chk("rst_count_p1", rdata_p1, 32'h0);
    chk("rst_irq_p1", {31'b0, irq_p1}, 32'h0);
    chk("rst_count_p4", rdata_p4, 32'h0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    m1 = mdl_zero();
    m4 = mdl_zero();
    do_reset();

    // All four offsets read zero after reset
    for (int a = 0; a < 4; a++) begin
      drive(1'b0, 4'(a * 4), 4'h0, 32'h0);
      chk("reset_read", rdata_p1, 32'h0);
      edge_update();
    end

    // One-shot, PRESET=5, PRESCALE=1
    wr(4'h4, 32'd5);
    wr(4'h0, 32'h9);
    rd(4'h8, 2);
    for (int v = 5; v >= 1; v--) begin
      drive(1'b0, 4'h8, 4'h0, 32'h0);
      chk("oneshot_count", rdata_p1, 32'(v));
      chk("oneshot_irq_low", {31'b0, irq_p1}, 32'h0);
      edge_update();
    end
    drive(1'b0, 4'h8, 4'h0, 32'h0);
    chk("oneshot_int_count", rdata_p1, 32'h0);
    chk("oneshot_int_irq", {31'b0, irq_p1}, 32'h1);
    edge_update();
    drive(1'b0, 4'h0, 4'h0, 32'h0);
    chk("oneshot_ctrl", rdata_p1, 32'h8);
    chk("oneshot_irq_held", {31'b0, irq_p1}, 32'h1);
    edge_update();
    wr(4'h0, 32'h8);
    drive(1'b0, 4'h0, 4'h0, 32'h0);
    chk("oneshot_irq_cleared", {31'b0, irq_p1}, 32'h0);
    edge_update();

    // PRESCALE=4, PRESET=2: each value held 4 cycles, INT after 8
    do_reset();
    wr(4'h4, 32'd2);
    wr(4'h0, 32'h9);
    rd(4'h8, 2);
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, 4'h8, 4'h0, 32'h0);
      chk("p4_count", rdata_p4, (c < 4) ? 32'd2 : 32'd1);
      chk("p4_irq_low", {31'b0, irq_p4}, 32'h0);
      edge_update();
    end
    drive(1'b0, 4'h8, 4'h0, 32'h0);
    chk("p4_int_irq", {31'b0, irq_p4}, 32'h1);
    edge_update();
    rd(4'h8, 3);

    // Auto-reload, PRESET=3, with a PRESET write mid-count
    do_reset();
    wr(4'h4, 32'd3);
    wr(4'h0, 32'hB);
    rd(4'h8, 5);
    drive(1'b0, 4'h8, 4'h0, 32'h0);
    chk("reload_pulse1", {31'b0, irq_p1}, 32'h1);
    edge_update();
    drive(1'b0, 4'h8, 4'h0, 32'h0);
    chk("reload_pulse1_end", {31'b0, irq_p1}, 32'h0);
    edge_update();
    drive(1'b0, 4'h8, 4'h0, 32'h0);
    chk("reload_count", rdata_p1, 32'd3);
    edge_update();
    wr(4'h4, 32'h1234);
    drive(1'b0, 4'h8, 4'h0, 32'h0);
    chk("preset_mid_count", rdata_p1, 32'd1);
    edge_update();
    drive(1'b0, 4'h8, 4'h0, 32'h0);
    chk("reload_pulse2", {31'b0, irq_p1}, 32'h1);
    edge_update();
    rd(4'h8, 1);
    drive(1'b0, 4'h8, 4'h0, 32'h0);
    chk("reload_new_preset", rdata_p1, 32'h1234);
    edge_update();

    // Disable during CNT freezes COUNT
    do_reset();
    wr(4'h4, 32'd10);
    wr(4'h0, 32'h9);
    rd(4'h8, 4);
    wr(4'h0, 32'h8);
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 4'h8, 4'h0, 32'h0);
      chk("frozen_count", rdata_p1, 32'd7);
      chk("frozen_irq", {31'b0, irq_p1}, 32'h0);
      edge_update();
    end

    // CTRL write in the one-shot INT cycle wins and restarts the timer
    do_reset();
    wr(4'h4, 32'd2);
    wr(4'h0, 32'h9);
    rd(4'h8, 4);
    drive(1'b1, 4'h0, 4'hF, 32'h9);
    chk("conflict_int_irq", {31'b0, irq_p1}, 32'h1);
    edge_update();
    drive(1'b0, 4'h0, 4'h0, 32'h0);
    chk("conflict_ctrl", rdata_p1, 32'h9);
    chk("conflict_irq", {31'b0, irq_p1}, 32'h0);
    edge_update();
    rd(4'h8, 1);
    drive(1'b0, 4'h8, 4'h0, 32'h0);
    chk("conflict_restart", rdata_p1, 32'd2);
    edge_update();

    // Reset asserted mid-count
    wr(4'h4, 32'd10);
    rd(4'h8, 3);
    do_reset();
    drive(1'b0, 4'h0, 4'h0, 32'h0);
    chk("midreset_ctrl", rdata_p1, 32'h0);
    edge_update();
    rd(4'h8, 4);

    // Randomized bus traffic checked against the model every cycle
    do_reset();
    for (int i = 0; i < 400; i++) begin
      int unsigned r;
      bit [3:0]    a, be;
      bit [31:0]   d;
      r  = $urandom_range(0, 9);
      a  = 4'($urandom_range(0, 15));
      be = 4'($urandom_range(0, 15));
      if (a[3:2] == 2'd1) d = 32'($urandom_range(0, 6));
      else                d = $urandom();
      if (r < 2) step(1'b1, a, be, d);
      else       step(1'b0, a, be, d);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bus_timer.md
Name: bus_timer

Overview:
- Memory-mapped countdown timer on the CPU's data-memory bus, directly downstream of the pipeline's M stage.
- Consumes the same address/wdata/byte-enable triple the core drives to data memory, after address decode selects the timer window.
- Returns read data combinationally in the same cycle, as data memory does.
- Raises an interrupt request when the count expires, in one-shot or auto-reload mode.

Parameters:
- PRESCALE, 1, clock cycles per count decrement; legal range 1..65535.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- sel  input  1  address decoder has selected the timer window this cycle.
- addr  input  4  byte address within the window; only [3:2] decoded.
- byteen  input  4  byte enables; write occurs when sel and byteen != 0.
- wdata  input  32  write data.
- rdata  output  32  combinational read data for addr[3:2].
- irq  output  1  interrupt request.

Behaviour:
- Register map, selected by addr[3:2]:
  - 00 CTRL: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00), [3] IM (interrupt mask, 1 = enabled).
  - 01 PRESET: 32-bit reload value.
  - 10 COUNT: read-only current value.
  - 11 reserved: reads 0, writes ignored.
- Writes:
  - CTRL updates bits [3:0] only when byteen[0]=1.
  - PRESET merges per byte under byteen.
  - Writes to COUNT and reserved are ignored.
- Reads: rdata = {28'b0, CTRL} / PRESET / COUNT / 0, independent of sel and byteen.
- Reset (async, active-low): CTRL=0, PRESET=0, COUNT=0, prescale counter=0, state IDLE, pending=0, irq=0. rdata then reflects these zeros.
- Tick: prescale counter counts 0..PRESCALE-1 while in CNT; tick asserted when it equals PRESCALE-1, then it wraps to 0. The counter is cleared in IDLE and LOAD. With PRESCALE=1, tick is asserted every CNT cycle.
- FSM, one transition per clock:
  - IDLE: if EN=1, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT: if EN=0, go to IDLE and hold COUNT. Otherwise, on tick: if COUNT > 1, COUNT decrements; else COUNT <= 0, pending <= 1, go to INT.
  - INT, one cycle: in MODE 01 go to LOAD; otherwise clear EN and go to IDLE.
- Latency: with EN written at cycle 0, LOAD occurs in cycle 2 and INT is entered N*PRESCALE cycles after LOAD for PRESET=N>=1. PRESET=0 behaves like PRESET=1.
- irq = pending & IM; registered path, no combinational dependence on bus inputs.
- Pending clear:
  - MODE 01: pending clears automatically on leaving INT, giving a one-cycle pulse.
  - MODE 00: pending stays set until any CTRL write.
- Simultaneous events:
  - A CPU CTRL write in the same cycle INT clears EN: the CPU write wins, including its EN value.
  - A PRESET write during CNT does not change COUNT; it takes effect at the next LOAD.
  - A CTRL write that sets EN=0 during CNT freezes COUNT in the next cycle.
  - A CTRL write with pending set and IM unchanged clears pending, so irq drops the next cycle.
- Reset asserted mid-count: returns immediately to the reset values above; no interrupt is generated.

Decomposition:
- Shared package holds:
  - register offsets (CTRL_OFF, PRESET_OFF, COUNT_OFF);
  - CTRL bit positions (EN_BIT, MODE_LSB, IM_BIT);
  - mode constants (MODE_ONESHOT, MODE_RELOAD);
  - FSM state encoding (IDLE, LOAD, CNT, INT, 2-bit).
- One natural sub-module: timer_prescaler, which owns the prescale counter and emits the tick, cleared by the FSM.

Test Plan:
- Reset, then read all four offsets -> rdata 0 for each; irq 0. Assert reset mid-count -> COUNT and state return to 0/IDLE immediately.
- PRESCALE=1; write PRESET=5, then CTRL=0x9 (EN, one-shot, IM) -> COUNT reads 5,4,3,2,1,0 on successive cycles after LOAD. irq rises in the INT cycle and stays high; CTRL reads 0x8. Writing CTRL=0x8 drops irq the next cycle.
- PRESCALE=1; PRESET=3, CTRL=0xB (auto-reload, IM) -> irq is a one-cycle pulse every 5 cycles (3 count + INT + LOAD); COUNT reloads to 3 each period.
- PRESCALE=4; PRESET=2, CTRL=0x9 -> COUNT holds each value for 4 cycles; INT entered 8 cycles after LOAD.
- Mid-count writes:
  - PRESET=0x1234 written during CNT -> current countdown is unaffected; next reload (auto-reload) loads 0x1234.
  - CTRL=0x8 written during CNT -> COUNT freezes and the FSM returns to IDLE.
- Same-cycle conflict: a CTRL=0x9 write coinciding with the one-shot INT cycle -> EN stays 1, pending clears, and the timer restarts via LOAD.
